truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Sequential response checker for 3-input combinational blocks in the boolean-minimization exercises. It sweeps all eight {A,B,C} input vectors into a device under test (DUT) and waits a programmable settle time per vector. It samples the DUT output F, builds the captured 8-bit minterm table and compares it against an expected table. It sits alongside the combinational DUT on the same clock and reports pass/fail plus a per-minterm mismatch mask.

## Interface
- `SETTLE_CYCLES`, default 2: number of clock cycles each vector is held before F is sampled; legal range is 1..15.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: pulse that begins a sweep; only honoured in IDLE.
- `exp_table` input, 8 bits: expected minterm mask, where bit i is the expected F for {A,B,C}=i; captured when start is accepted.
- `f_in` input, 1 bit: DUT output F, combinational from `abc`, same clock domain, no synchronizer.
- `abc` output, 3 bits: registered stimulus to the DUT; abc[2]=A, abc[1]=B, abc[0]=C.
- `busy` output, 1 bit: high while the sweep runs.
- `done` output, 1 bit: one-cycle pulse when the sweep completes.
- `cap_table` output, 8 bits: captured minterm mask.
- `mismatch` output, 8 bits: cap_table XOR expected table.
- `err_count` output, 4 bits: popcount of mismatch, range 0..8.
- `pass` output, 1 bit: high when mismatch == 0.

## Operation
- FSM has three states: IDLE, SWEEP, REPORT.
- IDLE, start=1:
  - latch exp_table;
  - clear cap_table, mismatch, err_count and pass;
  - abc <= 0, settle counter <= 0;
  - next state SWEEP.
- IDLE, start=0: hold all result outputs unchanged.
- SWEEP, settle counter < SETTLE_CYCLES-1: increment the counter; abc holds.
- SWEEP, settle counter == SETTLE_CYCLES-1:
  - cap_table[abc] <= f_in;
  - counter <= 0;
  - if abc==7, next state REPORT (abc stays 7); else abc <= abc+1.
- REPORT, one cycle:
  - mismatch <= cap_table ^ exp_latched;
  - err_count <= popcount of that value;
  - pass <= (that value == 0);
  - done <= 1;
  - next state IDLE.
- start while in SWEEP or REPORT is ignored; it is not queued.
- abc is not wrapped or incremented past 7.
- Reset values: abc=0, busy=0, done=0, cap_table=0, mismatch=0, err_count=0, pass=0, state IDLE.
- Reset mid-sweep: all of the above take effect immediately; the partial table is discarded; no done pulse.

## Timing
- Cycle 0 is the edge at which start is sampled high in IDLE.
- Cycles 1..8·SETTLE_CYCLES: busy=1.
  - Vector i is on abc during cycles i·S+1 .. (i+1)·S, where S = SETTLE_CYCLES.
  - f_in is sampled at the rising edge ending cycle (i+1)·S.
- Cycle 8·S+1: REPORT. busy=0, done=1, and mismatch/err_count/pass are valid.
- Results remain valid until the next accepted start.
- Total latency from start to done is 8·S+1 cycles; for S=2 that is 17.
- start may be asserted in the cycle immediately after done; it is accepted, giving back-to-back sweeps.
- The DUT path abc→F must settle within one clock period. S>1 exists only to provide margin for multi-cycle or registered DUTs.

## Structure
- Shared package `tt_pkg`:
  - state enum `tt_state_t` {IDLE, SWEEP, REPORT};
  - `TT_NVARS`=3, `TT_NMINTERMS`=8;
  - `tt_popcount8` function.
- No sub-module. The block is a single FSM plus counter and datapath.
- The reference DUT used in tests is the existing boolean_min-style combinational block, instantiated only in the bench.

## Test plan
- F = A&B | ~C, exp_table=8'hD5, S=2:
  - abc steps 0..7, two cycles each;
  - done at cycle 17;
  - cap_table=8'hD5, mismatch=0, err_count=0, pass=1.
- Same DUT with exp_table=8'hD4 -> mismatch=8'h01, err_count=1, pass=0.
- f_in tied 0, exp_table=8'hFF -> cap_table=8'h00, err_count=8, pass=0.
- S=1, f_in tied 1, exp_table=8'hFF:
  - done at cycle 9, pass=1;
  - start pulsed in cycle 3 is ignored: single sweep, single done.
- rst_n driven low at abc=4 mid-sweep -> all outputs return to reset values asynchronously; no done pulse. A new start after release sweeps from abc=0.
- start re-asserted the cycle after done -> second sweep begins immediately. Cleared outputs are observed in cycle 1 of that sweep, and correct results appear at the second done.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and helpers for the 3-input truth-table checker.
package tt_pkg;

    localparam int TT_NVARS     = 3;
    localparam int TT_NMINTERMS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        REPORT
    } tt_state_t;

    // Number of set bits in an 8-bit minterm mask (0..8).
    function automatic logic [3:0] tt_popcount8(input logic [TT_NMINTERMS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < TT_NMINTERMS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_checker.sv
// Sweeps {A,B,C} through all eight vectors, samples the DUT output after a
// programmable settle time, and compares the captured table with an expected one.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [TT_NMINTERMS-1:0] exp_table,
    input  logic                    f_in,
    output logic [TT_NVARS-1:0]     abc,
    output logic                    busy,
    output logic                    done,
    output logic [TT_NMINTERMS-1:0] cap_table,
    output logic [TT_NMINTERMS-1:0] mismatch,
    output logic [3:0]              err_count,
    output logic                    pass
);

    // Counter value at which the current vector has settled and F is sampled.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    tt_state_t               state;
    logic [3:0]              settle_cnt;
    logic [TT_NMINTERMS-1:0] exp_lat;

    // Sweep FSM with its counter and result datapath; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            exp_lat    <= '0;
            abc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cap_table  <= '0;
            mismatch   <= '0;
            err_count  <= 4'd0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Results from the previous sweep stay put until a new start.
                    if (start) begin
                        exp_lat    <= exp_table;
                        cap_table  <= '0;
                        mismatch   <= '0;
                        err_count  <= 4'd0;
                        pass       <= 1'b0;
                        abc        <= '0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        state      <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        cap_table[abc] <= f_in;
                        settle_cnt     <= 4'd0;
                        if (abc == 3'd7) begin
                            // Leave abc parked on the last vector.
                            busy  <= 1'b0;
                            state <= REPORT;
                        end else begin
                            abc <= abc + 3'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                REPORT: begin
                    mismatch  <= cap_table ^ exp_lat;
                    err_count <= tt_popcount8(cap_table ^ exp_lat);
                    pass      <= (cap_table == exp_lat);
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (S=2 and S=1), each driven by a
// behavioural DUT that looks up F from a bench-owned truth table.
module tb_truth_table_checker;

    logic       clk;
    logic       rst_n   [2];
    logic       start   [2];
    logic [7:0] exp_t   [2];
    logic       f       [2];
    logic [2:0] abc     [2];
    logic       busy    [2];
    logic       done    [2];
    logic [7:0] cap     [2];
    logic [7:0] mism    [2];
    logic [3:0] errc    [2];
    logic       pass    [2];

    // Truth table of the device being checked, per instance.
    logic [7:0] dut_tab [2];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign f[0] = dut_tab[0][abc[0]];
    assign f[1] = dut_tab[1][abc[1]];

    truth_table_checker #(.SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .exp_table(exp_t[0]),
        .f_in(f[0]), .abc(abc[0]), .busy(busy[0]), .done(done[0]),
        .cap_table(cap[0]), .mismatch(mism[0]), .err_count(errc[0]), .pass(pass[0])
    );

    truth_table_checker #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .exp_table(exp_t[1]),
        .f_in(f[1]), .abc(abc[1]), .busy(busy[1]), .done(done[1]),
        .cap_table(cap[1]), .mismatch(mism[1]), .err_count(errc[1]), .pass(pass[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_of(input int j);
        return (j == 0) ? 2 : 1;
    endfunction

    // F = A&B | ~C, built from the boolean rule rather than a constant.
    function automatic logic [7:0] ab_or_nc();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = ((i >> 2) & (i >> 1) & 1) != 0 || (i & 1) == 0;
        end
        return t;
    endfunction

    // One complete sweep on instance j. Call #1 after a rising edge.
    // ign_at > 0 pulses start during that cycle of the sweep to prove it is ignored.
    task automatic run(input int j, input logic [7:0] tab, input logic [7:0] exp, input int ign_at);
        int s, last;
        logic [7:0] want_mis;
        s = settle_of(j);
        last = 8 * s + 1;
        dut_tab[j] = tab;
        exp_t[j]   = exp;
        start[j]   = 1'b1;
        @(posedge clk); #1;
        start[j]   = 1'b0;
        exp_t[j]   = ~exp;  // latched at start; later changes must not matter
        check($sformatf("clr_busy%0d", j), busy[j], 1);
        check($sformatf("clr_done%0d", j), done[j], 0);
        check($sformatf("clr_cap%0d", j), cap[j], 0);
        check($sformatf("clr_mis%0d", j), mism[j], 0);
        check($sformatf("clr_err%0d", j), errc[j], 0);
        check($sformatf("clr_pass%0d", j), pass[j], 0);
        check($sformatf("abc_k0_%0d", j), abc[j], 0);
        for (int k = 1; k <= last; k++) begin
            if (k == ign_at) start[j] = 1'b1;
            @(posedge clk); #1;
            start[j] = 1'b0;
            check($sformatf("done%0d_k%0d", j, k), done[j], (k == last));
            check($sformatf("busy%0d_k%0d", j, k), busy[j], (k < 8 * s));
            check($sformatf("abc%0d_k%0d", j, k), abc[j], (k < 8 * s) ? k / s : 7);
        end
        want_mis = tab ^ exp;
        check($sformatf("cap%0d", j), cap[j], tab);
        check($sformatf("mis%0d", j), mism[j], want_mis);
        check($sformatf("err%0d", j), errc[j], $countones(want_mis));
        check($sformatf("pass%0d", j), pass[j], (tab == exp));
    endtask

    initial begin
        logic [7:0] t, e;
        int j;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; exp_t[i] = 8'h00; dut_tab[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_abc%0d", i), abc[i], 0);
            check($sformatf("rst_busy%0d", i), busy[i], 0);
            check($sformatf("rst_done%0d", i), done[i], 0);
            check($sformatf("rst_cap%0d", i), cap[i], 0);
            check($sformatf("rst_mis%0d", i), mism[i], 0);
            check($sformatf("rst_err%0d", i), errc[i], 0);
            check($sformatf("rst_pass%0d", i), pass[i], 0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the boolean-minimization exercise.
        check("abnc_table", ab_or_nc(), 8'hD5);
        run(0, ab_or_nc(), 8'hD5, 0);
        run(0, ab_or_nc(), 8'hD4, 0);    // back-to-back with the previous sweep
        run(0, 8'h00, 8'hFF, 0);
        run(1, 8'hFF, 8'hFF, 3);         // stray start mid-sweep
        @(posedge clk); #1;
        check("s1_no_second_sweep", busy[1], 0);
        check("s1_no_second_done", done[1], 0);

        // Reset mid-sweep once abc reaches 4 (after edge 8 at S=2).
        dut_tab[0] = 8'hA5; exp_t[0] = 8'hA5; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_abc", abc[0], 4);
        #2 rst_n[0] = 1'b0;
        #1;
        check("mid_rst_abc", abc[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_cap", cap[0], 0);
        check("mid_rst_mis", mism[0], 0);
        check("mid_rst_err", errc[0], 0);
        check("mid_rst_pass", pass[0], 0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("rst_hold_done", done[0], 0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", done[0], 0);
        run(0, 8'h3C, 8'h3C, 0);

        // Random tables with random error patterns on both instances.
        for (int n = 0; n < 8; n++) begin
            j = $urandom_range(0, 1);
            t = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? t : (t ^ 8'($urandom));
            run(j, t, e, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
